// File: rtl/sram_bus_arbiter.sv
// Arbiter sharing one sram-like slave port between the inst-fetch and data masters.
// Optional round-robin tie-breaking is enabled with `define SRAM_ARB_ROUND_ROBIN_EN.
module sram_bus_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int CNT_W       = $clog2(OUTSTANDING) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_req,
  input  logic             i_wr,
  input  logic [1:0]       i_size,
  input  logic [31:0]      i_addr,
  input  logic [3:0]       i_wstrb,
  input  logic [31:0]      i_wdata,
  output logic             i_addr_ok,
  output logic             i_data_ok,
  output logic [31:0]      i_rdata,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [1:0]       d_size,
  input  logic [31:0]      d_addr,
  input  logic [3:0]       d_wstrb,
  input  logic [31:0]      d_wdata,
  output logic             d_addr_ok,
  output logic             d_data_ok,
  output logic [31:0]      d_rdata,
  output logic             req,
  output logic             wr,
  output logic [1:0]       size,
  output logic [31:0]      addr,
  output logic [3:0]       wstrb,
  output logic [31:0]      wdata,
  input  logic             addr_ok,
  input  logic             data_ok,
  input  logic [31:0]      rdata,
  output logic [CNT_W-1:0] outstanding,
  output logic             protocol_err
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;
  localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(OUTSTANDING);

  logic [OUTSTANDING-1:0] tag_r;
  logic [PW-1:0]          head_r;
  logic [PW-1:0]          tail_r;
  logic [CNT_W-1:0]       count_r;
  logic                   lock_r;
  logic                   lock_id_r;
  logic                   perr_r;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic                   rr_r;
`endif

  logic full_s;
  logic empty_s;
  logic grant_s;
  logic gnt_req_s;
  logic req_s;
  logic push_s;
  logic pop_s;

  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);

  // Grant selection: a locked request keeps its owner until the slave accepts it.
  always_comb begin
    grant_s = ID_INST;
    if (lock_r) begin
      grant_s = lock_id_r;
    end else if (d_req && i_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      grant_s = ~rr_r;
`else
      grant_s = ID_DATA;
`endif
    end else if (d_req) begin
      grant_s = ID_DATA;
    end else begin
      grant_s = ID_INST;
    end
  end

  assign gnt_req_s = (grant_s == ID_DATA) ? d_req : i_req;
  // No bypass when full: a pop in the same cycle does not free a slot until the next.
  assign req_s     = resetn & ~full_s & gnt_req_s;
  assign push_s    = req_s & addr_ok;
  assign pop_s     = resetn & data_ok & ~empty_s;

  // Slave-side request mux and master handshake outputs, forced quiet in reset.
  always_comb begin
    req       = 1'b0;
    wr        = 1'b0;
    size      = 2'b00;
    addr      = 32'h0000_0000;
    wstrb     = 4'b0000;
    wdata     = 32'h0000_0000;
    i_addr_ok = 1'b0;
    d_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    d_data_ok = 1'b0;
    if (resetn) begin
      req       = req_s;
      wr        = (grant_s == ID_DATA) ? d_wr    : i_wr;
      size      = (grant_s == ID_DATA) ? d_size  : i_size;
      addr      = (grant_s == ID_DATA) ? d_addr  : i_addr;
      wstrb     = (grant_s == ID_DATA) ? d_wstrb : i_wstrb;
      wdata     = (grant_s == ID_DATA) ? d_wdata : i_wdata;
      i_addr_ok = push_s & (grant_s == ID_INST);
      d_addr_ok = push_s & (grant_s == ID_DATA);
      i_data_ok = pop_s & (tag_r[head_r] == ID_INST);
      d_data_ok = pop_s & (tag_r[head_r] == ID_DATA);
    end else begin
      req = 1'b0;
    end
  end

  assign i_rdata      = rdata;
  assign d_rdata      = rdata;
  assign outstanding  = count_r;
  assign protocol_err = perr_r;

  // Tag FIFO, occupancy counter, request lock and sticky protocol error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_r     <= '0;
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= CNT_ZERO;
      lock_r    <= 1'b0;
      lock_id_r <= ID_INST;
      perr_r    <= 1'b0;
    end else begin
      if (push_s) begin
        tag_r[tail_r] <= grant_s;
        tail_r        <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (push_s) begin
        lock_r <= 1'b0;
      end else if (req_s) begin
        lock_r    <= 1'b1;
        lock_id_r <= grant_s;
      end
      if (data_ok && empty_s) begin
        perr_r <= 1'b1;
      end
    end
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Remember the last accepted master so the next tie goes the other way.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_r <= ID_INST;
    end else if (push_s) begin
      rr_r <= grant_s;
    end
  end
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: stimulus queues expected handshakes and
// responses, a negedge monitor pops and compares whenever the DUT signals one.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size, size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, addr, wdata, rdata;
  logic [3:0]  i_wstrb, d_wstrb, wstrb;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        req, wr, addr_ok, data_ok;
  logic [2:0]  outstanding;
  logic        protocol_err;

  int total = 0;
  int bad   = 0;

  bit          hs_q[$];
  bit          tag_model[$];
  logic [32:0] resp_q[$];

  sram_bus_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr),
    .i_wstrb(i_wstrb), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .outstanding(outstanding), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input bit id);
    hs_q.push_back(id);
    tag_model.push_back(id);
  endtask

  task automatic expect_resp(input logic [31:0] r);
    bit id;
    id = tag_model.pop_front();
    resp_q.push_back({id, r});
  endtask

  task automatic drain(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      data_ok = 1'b1;
      rdata   = base + 32'(k);
      expect_resp(rdata);
      tick();
    end
    data_ok = 1'b0;
  endtask

  // Monitor: address handshakes and responses checked against the queues.
  always @(negedge clk) begin
    bit          id;
    logic [32:0] e;
    if (i_addr_ok || d_addr_ok) begin
      chk("addr_ok_onehot", {31'd0, i_addr_ok & d_addr_ok}, 32'd0);
      if (hs_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_addr_ok: i=%b d=%b expected none", i_addr_ok, d_addr_ok);
      end else begin
        id = hs_q.pop_front();
        chk("addr_ok_owner", {31'd0, d_addr_ok}, {31'd0, id});
      end
    end
    if (i_data_ok || d_data_ok) begin
      if (resp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_data_ok: i=%b d=%b expected none", i_data_ok, d_data_ok);
      end else begin
        e = resp_q.pop_front();
        chk("data_ok_owner", {30'd0, i_data_ok, d_data_ok}, e[32] ? 32'd1 : 32'd2);
        chk("i_rdata", i_rdata, e[31:0]);
        chk("d_rdata", d_rdata, e[31:0]);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    i_req = 1'b1; i_wr = 1'b0; i_size = 2'b10; i_addr = 32'h0; i_wstrb = 4'hf; i_wdata = 32'h0;
    d_req = 1'b0; d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h0; d_wstrb = 4'hf; d_wdata = 32'h0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'hdeadbeef;

    @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_outstanding", {29'd0, outstanding}, 32'd0);
    chk("rst_protocol_err", {31'd0, protocol_err}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'hdeadbeef);
    chk("rst_d_rdata", d_rdata, 32'hdeadbeef);
    i_req = 1'b0;
    tick();
    resetn = 1'b1;

    // single inst read, accepted same cycle, returned next cycle
    i_req = 1'b1; i_addr = 32'h1c000000; addr_ok = 1'b1;
    expect_issue(1'b0);
    @(negedge clk);
    chk("t1_req", {31'd0, req}, 32'd1);
    chk("t1_addr", addr, 32'h1c000000);
    tick();
    i_req = 1'b0; addr_ok = 1'b0;
    chk("t1_outstanding1", {29'd0, outstanding}, 32'd1);
    data_ok = 1'b1; rdata = 32'h02800000;
    expect_resp(rdata);
    tick();
    data_ok = 1'b0;
    chk("t1_outstanding0", {29'd0, outstanding}, 32'd0);

    // tie: data first, then inst
    i_req = 1'b1; i_addr = 32'h1c000004; d_req = 1'b1; d_addr = 32'h1c010000; addr_ok = 1'b1;
    expect_issue(1'b1);
    @(negedge clk);
    chk("t2_addr_data", addr, 32'h1c010000);
    tick();
    d_req = 1'b0;
    expect_issue(1'b0);
    @(negedge clk);
    chk("t2_addr_inst", addr, 32'h1c000004);
    tick();
    i_req = 1'b0; addr_ok = 1'b0;
    chk("t2_outstanding", {29'd0, outstanding}, 32'd2);
    drain(2, 32'ha0000000);

    // lock holds inst request while slave stalls
    i_req = 1'b1; i_addr = 32'h1c000004; d_addr = 32'h1c010000;
    @(negedge clk);
    chk("t3_addr_c0", addr, 32'h1c000004);
    tick();
    d_req = 1'b1;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      chk("t3_addr_locked", addr, 32'h1c000004);
      chk("t3_req_locked", {31'd0, req}, 32'd1);
      tick();
    end
    addr_ok = 1'b1;
    expect_issue(1'b0);
    @(negedge clk);
    chk("t3_addr_c3", addr, 32'h1c000004);
    tick();
    i_req = 1'b0;
    expect_issue(1'b1);
    tick();
    d_req = 1'b0; addr_ok = 1'b0;
    chk("t3_outstanding", {29'd0, outstanding}, 32'd2);
    drain(2, 32'hb0000000);

    // fill the FIFO, no bypass when full
    i_req = 1'b1; i_addr = 32'h1c000100; addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_issue(1'b0);
      tick();
    end
    @(negedge clk);
    chk("t4_full_cnt", {29'd0, outstanding}, 32'd4);
    chk("t4_full_req", {31'd0, req}, 32'd0);
    tick();
    data_ok = 1'b1; rdata = 32'hc0000000;
    expect_resp(rdata);
    @(negedge clk);
    chk("t4_nobypass_req", {31'd0, req}, 32'd0);
    tick();
    data_ok = 1'b0;
    expect_issue(1'b0);
    @(negedge clk);
    chk("t4_after_pop_cnt", {29'd0, outstanding}, 32'd3);
    chk("t4_after_pop_req", {31'd0, req}, 32'd1);
    tick();
    i_req = 1'b0; addr_ok = 1'b0;
    chk("t4_refill_cnt", {29'd0, outstanding}, 32'd4);
    drain(4, 32'hc0000010);

    // two outstanding, simultaneous push and pop across pointer wrap
    d_req = 1'b1; d_addr = 32'h1c020000; addr_ok = 1'b1;
    expect_issue(1'b1);
    tick();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h1c000200;
    expect_issue(1'b0);
    tick();
    for (int k = 0; k < 6; k++) begin
      logic [5:0] pat;
      pat = 6'b101101;
      d_req = pat[k]; i_req = ~pat[k];
      data_ok = 1'b1; rdata = 32'hd0000000 + 32'(k);
      expect_resp(rdata);
      expect_issue(pat[k]);
      @(negedge clk);
      chk("t6_outstanding", {29'd0, outstanding}, 32'd2);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    chk("t6_cnt_after", {29'd0, outstanding}, 32'd2);
    drain(2, 32'he0000000);
    chk("t6_cnt_drained", {29'd0, outstanding}, 32'd0);

    // data_ok with empty FIFO, then async reset clears the sticky error
    data_ok = 1'b1; rdata = 32'hf0000000;
    @(negedge clk);
    chk("t5_i_data_ok", {31'd0, i_data_ok}, 32'd0);
    chk("t5_d_data_ok", {31'd0, d_data_ok}, 32'd0);
    tick();
    data_ok = 1'b0;
    chk("t5_perr_set", {31'd0, protocol_err}, 32'd1);
    tick();
    chk("t5_perr_sticky", {31'd0, protocol_err}, 32'd1);
    i_req = 1'b1; rdata = 32'h12345678;
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_perr_reset", {31'd0, protocol_err}, 32'd0);
    chk("t5_req_reset", {31'd0, req}, 32'd0);
    chk("t5_rdata_reset", i_rdata, 32'h12345678);
    i_req = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    chk("hs_queue_empty", 32'(hs_q.size()), 32'd0);
    chk("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
